// File: rtl/tuning_controller.sv
// rtl/tuning_controller.sv - UART command sequencer for NCO phase increment and CIC gain
module tuning_controller #(
   parameter int                  PHASE_WIDTH   = 64,
   parameter int                  GAIN_WIDTH    = 8,
   parameter logic [PHASE_WIDTH-1:0] STEP_9K       = 64'h71b375868d170,
   parameter logic [PHASE_WIDTH-1:0] STEP_1K       = 64'hca22980ba57e,
   parameter logic [PHASE_WIDTH-1:0] STEP_100      = 64'h1436a8cdf6f3,
   parameter logic [PHASE_WIDTH-1:0] PRESET_A      = 64'h4CF41F212D77318,
   parameter logic [PHASE_WIDTH-1:0] PRESET_B      = 64'h1aa60f8b8911654,
   parameter logic [PHASE_WIDTH-1:0] PRESET_F      = 64'h1dc38c076704516d,
   parameter logic [PHASE_WIDTH-1:0] PRESET_G      = 64'h1d60d923295482c6,
   parameter logic [PHASE_WIDTH-1:0] MAX_PHASE_INC = 64'h7FFFFFFFFFFFFFFF,
   parameter int                  HEX_TIMEOUT   = 80000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_data_valid,
   input  logic [7:0]             rx_byte,
   input  logic                   tx_busy,
   output logic                   tx_start,
   output logic [7:0]             tx_byte,
   output logic [PHASE_WIDTH-1:0] phase_inc,
   output logic                   phase_inc_update,
   output logic [GAIN_WIDTH-1:0]  cic_gain
);

   localparam logic [7:0] ACK_OK  = 8'h21;
   localparam logic [7:0] ACK_ERR = 8'h3F;
   localparam int         TMO_W   = $clog2(HEX_TIMEOUT + 1);

   typedef enum logic {IDLE, HEX} state_t;

   state_t                 state, state_n;
   logic [PHASE_WIDTH-1:0] phase_n, shift_reg, shift_n, shift_next_digit, step_mag;
   logic [GAIN_WIDTH-1:0]  gain_n;
   logic                   update_n;
   logic [3:0]             digit_cnt, digit_cnt_n, nibble;
   logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_n;
   logic                   hex_ok, step_en, step_down;
   logic [PHASE_WIDTH:0]   step_sum;
   logic                   ack_gen, ack_pending;
   logic [7:0]             ack_val, ack_byte;

   // Command decode, hex entry and timeout: next values for all state registers
   always_comb begin
      state_n          = state;
      phase_n          = phase_inc;
      gain_n           = cic_gain;
      update_n         = 1'b0;
      shift_n          = shift_reg;
      digit_cnt_n      = digit_cnt;
      tmo_cnt_n        = tmo_cnt;
      ack_gen          = 1'b0;
      ack_val          = ACK_OK;
      step_en          = 1'b0;
      step_down        = 1'b0;
      step_mag         = '0;
      step_sum         = '0;
      hex_ok           = 1'b1;
      nibble           = 4'd0;
      shift_next_digit = '0;

      if (rx_byte >= "0" && rx_byte <= "9")
         nibble = rx_byte[3:0];
      else if ((rx_byte >= "a" && rx_byte <= "f") || (rx_byte >= "A" && rx_byte <= "F"))
         nibble = rx_byte[3:0] + 4'd9;
      else
         hex_ok = 1'b0;
      shift_next_digit = {shift_reg[PHASE_WIDTH-5:0], nibble};

      case (state)
         IDLE: begin
            tmo_cnt_n = '0;
            if (rx_data_valid) begin
               ack_gen = 1'b1;
               case (rx_byte)
                  "0", "1", "2", "3": gain_n = GAIN_WIDTH'(rx_byte[1:0]);
                  "a": begin phase_n = PRESET_A; update_n = 1'b1; end
                  "b": begin phase_n = PRESET_B; update_n = 1'b1; end
                  "f": begin phase_n = PRESET_F; update_n = 1'b1; end
                  "g": begin phase_n = PRESET_G; update_n = 1'b1; end
                  "m": begin step_en = 1'b1; step_mag = STEP_9K;  end
                  "n": begin step_en = 1'b1; step_mag = STEP_9K;  step_down = 1'b1; end
                  "h": begin step_en = 1'b1; step_mag = STEP_1K;  end
                  "q": begin step_en = 1'b1; step_mag = STEP_1K;  step_down = 1'b1; end
                  "p": begin step_en = 1'b1; step_mag = STEP_100; end
                  "o": begin step_en = 1'b1; step_mag = STEP_100; step_down = 1'b1; end
                  "x": begin
                     ack_gen     = 1'b0;
                     state_n     = HEX;
                     shift_n     = '0;
                     digit_cnt_n = 4'd0;
                  end
                  default: ack_val = ACK_ERR;
               endcase
               // Steps saturate at 0 and MAX_PHASE_INC; a saturated step still strobes
               if (step_en) begin
                  update_n = 1'b1;
                  if (step_down) begin
                     phase_n = (phase_inc < step_mag) ? '0 : phase_inc - step_mag;
                  end else begin
                     step_sum = {1'b0, phase_inc} + {1'b0, step_mag};
                     phase_n  = (step_sum > {1'b0, MAX_PHASE_INC}) ? MAX_PHASE_INC
                                                                   : step_sum[PHASE_WIDTH-1:0];
                  end
               end
            end
         end
         HEX: begin
            if (rx_data_valid) begin
               tmo_cnt_n = '0;
               if (hex_ok) begin
                  shift_n     = shift_next_digit;
                  digit_cnt_n = digit_cnt + 4'd1;
                  if (digit_cnt == 4'd15) begin
                     state_n = IDLE;
                     ack_gen = 1'b1;
                     if (shift_next_digit <= MAX_PHASE_INC) begin
                        phase_n  = shift_next_digit;
                        update_n = 1'b1;
                     end else begin
                        ack_val = ACK_ERR;
                     end
                  end
               end else begin
                  state_n = IDLE;
                  ack_gen = 1'b1;
                  ack_val = ACK_ERR;
               end
            end else if (tmo_cnt == TMO_W'(HEX_TIMEOUT - 1)) begin
               state_n = IDLE;
               ack_gen = 1'b1;
               ack_val = ACK_ERR;
            end else begin
               tmo_cnt_n = tmo_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State registers plus the one-entry ack holding register feeding uart_tx
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         phase_inc        <= PRESET_A;
         cic_gain         <= '0;
         phase_inc_update <= 1'b0;
         shift_reg        <= '0;
         digit_cnt        <= 4'd0;
         tmo_cnt          <= '0;
         tx_start         <= 1'b0;
         tx_byte          <= 8'h00;
         ack_pending      <= 1'b0;
         ack_byte         <= 8'h00;
      end else begin
         state            <= state_n;
         phase_inc        <= phase_n;
         cic_gain         <= gain_n;
         phase_inc_update <= update_n;
         shift_reg        <= shift_n;
         digit_cnt        <= digit_cnt_n;
         tmo_cnt          <= tmo_cnt_n;
         tx_start         <= ack_pending && !tx_busy;
         if (ack_pending && !tx_busy)
            tx_byte <= ack_byte;
         // A fresh ack always wins the holding register, even over one being sent now
         if (ack_gen) begin
            ack_pending <= 1'b1;
            ack_byte    <= ack_val;
         end else if (!tx_busy) begin
            ack_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tuning_controller.sv
// tb/tb_tuning_controller.sv - randomized self-checking bench for tuning_controller
module tb_tuning_controller;

   localparam int          TMO      = 100;
   localparam logic [63:0] STEP_9K  = 64'h71b375868d170;
   localparam logic [63:0] STEP_1K  = 64'hca22980ba57e;
   localparam logic [63:0] STEP_100 = 64'h1436a8cdf6f3;
   localparam logic [63:0] PRE_A    = 64'h4CF41F212D77318;
   localparam logic [63:0] PRE_B    = 64'h1aa60f8b8911654;
   localparam logic [63:0] PRE_F    = 64'h1dc38c076704516d;
   localparam logic [63:0] PRE_G    = 64'h1d60d923295482c6;
   localparam logic [63:0] MAXP     = 64'h7FFFFFFFFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_data_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        tx_busy = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic [63:0] phase_inc;
   logic        phase_inc_update;
   logic [7:0]  cic_gain;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [63:0] m_phase, m_val;
   logic [7:0]  m_gain;
   logic        m_upd;
   bit          m_hex;
   int          m_nd, m_idle;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];

   string lower = "0123456789abcdef";
   string upper = "0123456789ABCDEF";
   string pool  = "0123abfgmnhqpoxzk?9cF";

   tuning_controller #(.HEX_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data_valid(rx_data_valid), .rx_byte(rx_byte),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte), .phase_inc(phase_inc),
      .phase_inc_update(phase_inc_update), .cic_gain(cic_gain)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (tx_start) got_q.push_back(tx_byte);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int hex_val(input logic [7:0] b);
      for (int i = 0; i < 16; i++)
         if (b == lower[i] || b == upper[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = PRE_A; m_gain = 0; m_upd = 0; m_hex = 0; m_nd = 0; m_idle = 0; m_val = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [64:0] s;
      int nib;
      m_upd = 0;
      m_idle = 0;
      if (m_hex) begin
         nib = hex_val(b);
         if (nib < 0) begin
            m_hex = 0; exp_q.push_back("?");
         end else begin
            m_val = m_val * 16 + 64'(nib);
            m_nd++;
            if (m_nd == 16) begin
               m_hex = 0;
               if (m_val <= MAXP) begin
                  m_phase = m_val; m_upd = 1; exp_q.push_back("!");
               end else exp_q.push_back("?");
            end
         end
      end else begin
         case (b)
            "0", "1", "2", "3": begin m_gain = b - "0"; exp_q.push_back("!"); end
            "a": begin m_phase = PRE_A; m_upd = 1; exp_q.push_back("!"); end
            "b": begin m_phase = PRE_B; m_upd = 1; exp_q.push_back("!"); end
            "f": begin m_phase = PRE_F; m_upd = 1; exp_q.push_back("!"); end
            "g": begin m_phase = PRE_G; m_upd = 1; exp_q.push_back("!"); end
            "m", "h", "p": begin
               s = 65'(m_phase) + 65'(b == "m" ? STEP_9K : b == "h" ? STEP_1K : STEP_100);
               m_phase = (s > 65'(MAXP)) ? MAXP : s[63:0];
               m_upd = 1; exp_q.push_back("!");
            end
            "n", "q", "o": begin
               s = 65'(b == "n" ? STEP_9K : b == "q" ? STEP_1K : STEP_100);
               m_phase = (65'(m_phase) < s) ? 64'd0 : m_phase - s[63:0];
               m_upd = 1; exp_q.push_back("!");
            end
            "x": begin m_hex = 1; m_nd = 0; m_val = 0; end
            default: exp_q.push_back("?");
         endcase
      end
   endtask

   // called at a negedge; returns at the next negedge with outputs checked
   task automatic send(input logic [7:0] b);
      rx_byte = b; rx_data_valid = 1'b1;
      @(negedge clk);
      rx_data_valid = 1'b0;
      model_byte(b);
      check("phase_inc", phase_inc, m_phase);
      check("cic_gain", cic_gain, m_gain);
      check("update", phase_inc_update, m_upd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (m_hex) begin
            m_idle++;
            if (m_idle >= TMO) begin m_hex = 0; exp_q.push_back("?"); end
         end
      end
   endtask

   task automatic flush_acks(input string tag);
      idle(4);
      check({tag, "_ack_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_ack"}, got_q[i], exp_q[i]);
      got_q.delete(); exp_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      model_reset();
      got_q.delete(); exp_q.delete();
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();
      check("rst_phase", phase_inc, PRE_A);
      check("rst_gain", cic_gain, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_byte", tx_byte, 0);
      check("rst_update", phase_inc_update, 0);

      send("b");
      check("b_phase", phase_inc, 64'h1aa60f8b8911654);
      idle(1);
      check("b_update_low", phase_inc_update, 0);
      flush_acks("b");

      do_reset();
      for (int i = 0; i < 600; i++) send("n");
      check("n_floor", phase_inc, 0);
      flush_acks("n600");

      send("x"); send_str("0123456789ABCDEF");
      check("hex_load", phase_inc, 64'h0123456789ABCDEF);
      send("x"); send_str("8000000000000000");
      check("hex_over", phase_inc, 64'h0123456789ABCDEF);
      flush_acks("hex");

      send("x"); send_str("12"); send("z"); send("a");
      flush_acks("abort");

      send("x"); send("1");
      idle(90);
      check("tmo_early", got_q.size(), 0);
      idle(15);
      send("1");
      flush_acks("timeout");

      tx_busy = 1'b1;
      send("2"); send("k");
      check("busy_gain", cic_gain, 2);
      idle(5);
      check("busy_hold", got_q.size(), 0);
      tx_busy = 1'b0;
      idle(5);
      check("busy_count", got_q.size(), 1);
      if (got_q.size() > 0) check("busy_byte", got_q[0], "?");
      got_q.delete(); exp_q.delete();

      send("x"); send_str("12");
      rst_n = 1'b0; rx_byte = "b"; rx_data_valid = 1'b1;
      @(negedge clk);
      rx_data_valid = 1'b0; rst_n = 1'b1;
      model_reset(); got_q.delete(); exp_q.delete();
      check("rst_prio_phase", phase_inc, PRE_A);
      send("3");
      flush_acks("rst_mid_hex");

      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 30; i++) begin
            send(pool[$urandom_range(pool.len() - 1)]);
            idle($urandom_range(2));
         end
         send("x");
         for (int i = 0; i < 16; i++) begin
            if (i == 0) send(upper[$urandom_range(15)]);
            else if ($urandom_range(1) == 1) send(upper[$urandom_range(15)]);
            else send(lower[$urandom_range(15)]);
            idle($urandom_range(1));
         end
      end
      if (m_hex) send("z");
      flush_acks("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
